// File: rtl/sync_fifo_32x4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_32x4 : 32 x 4-bit single-clock FIFO with registered pop data,
// occupancy count, full/empty flags and reject pulses.  Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo_32x4 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_w;
  logic             empty_w;
  logic             rd_acc;
  logic             wr_acc;

  // Flags come only from registered occupancy, never from the request inputs.
  assign full_w  = (count_q == FULL_COUNT);
  assign empty_w = (count_q == '0);

  assign rd_acc = rd_en && !empty_w;
  assign wr_acc = wr_en && (!full_w || rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_acc;
    overflow_d   = wr_en && !wr_acc;
    underflow_d  = rd_en && !rd_acc;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      // Array read sees pre-edge contents, so a same-address write when full
      // still returns the oldest word.
      dout_d   = mem[rd_ptr_q];
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire
